// File: rtl/shift_pkg.sv
// Shared types and constants for the iterative shifter: op and FSM state encodings,
// plus datapath widths.
package shift_pkg;
  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;
endpackage

// File: rtl/shift_reg_unit_step.sv
// shift_step: one-position combinational shift of a 32-bit value by op.
// op=11 rotates right only when SHIFT_REG_ROTATE_EN is defined, otherwise it zero-fills like SRL.
module shift_step
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0] value,
  input  logic [1:0]        op,
  output logic [DATA_W-1:0] result
);
  always_comb begin
    result = {1'b0, value[DATA_W-1:1]};
    case (op)
      OP_SLL: result = {value[DATA_W-2:0], 1'b0};
      OP_SRL: result = {1'b0, value[DATA_W-1:1]};
      OP_SRA: result = {value[DATA_W-1], value[DATA_W-1:1]};
`ifdef SHIFT_REG_ROTATE_EN
      OP_ROR: result = {value[0], value[DATA_W-1:1]};
`else
      OP_ROR: result = {1'b0, value[DATA_W-1:1]};
`endif
      default: result = {1'b0, value[DATA_W-1:1]};
    endcase
  end
endmodule

// File: rtl/shift_reg_unit.sv
// Iterative one-bit-per-clock shifter for the multicycle datapath (SLL/SRL/SRA, optional
// rotate-right under SHIFT_REG_ROTATE_EN). busy/done are registered alongside the state.
module shift_reg_unit
  import shift_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [4:0]  shamt,
  input  logic [31:0] data_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] shift_reg_output
);
  state_e             state;
  shift_op_e          op_q;
  logic [SHAMT_W-1:0] cnt;
  logic [DATA_W-1:0]  step_out;

  shift_step u_step (
    .value  (shift_reg_output),
    .op     (op_q),
    .result (step_out)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= IDLE;
      cnt              <= '0;
      op_q             <= OP_SLL;
      shift_reg_output <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shift_reg_output <= data_in;
            op_q             <= shift_op_e'(op);
            cnt              <= shamt;
            busy             <= 1'b1;
            if (shamt != '0) begin
              state <= SHIFT;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          shift_reg_output <= step_out;
          if (cnt != '0) cnt <= cnt - 5'd1;
          // Last step: counter 1 -> 0 ends the shift
          if (cnt == 5'd1) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_shift_reg_unit.sv
// Scoreboard bench for shift_reg_unit: driver pushes reference results computed with
// plain shift operators; a negedge monitor checks busy/done timing and pops on done.
module tb_shift_reg_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [4:0]  shamt;
  logic [31:0] data_in;
  logic        busy, done;
  logic [31:0] shift_reg_output;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_lo = 1, exp_hi = 0, exp_done = -1;
  logic [31:0] exp_q[$];

  shift_reg_unit dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .op               (op),
    .shamt            (shamt),
    .data_in          (data_in),
    .busy             (busy),
    .done             (done),
    .shift_reg_output (shift_reg_output)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [31:0] model(input logic [1:0] o, input int s, input logic [31:0] d);
    case (o)
      2'b00: return d << s;
      2'b10: return $unsigned($signed(d) >>> s);
`ifdef SHIFT_REG_ROTATE_EN
      2'b11: return (d >> s) | (s == 0 ? 32'h0 : d << (32 - s));
`endif
      default: return d >> s;
    endcase
  endfunction

  // Monitor: timing against model windows, result popped on every done
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      checks++;
      if (busy !== (cyc >= exp_lo && cyc <= exp_hi)) begin
        errors++;
        $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, (cyc >= exp_lo && cyc <= exp_hi));
      end
      checks++;
      if (done !== (cyc == exp_done)) begin
        errors++;
        $display("FAIL done cyc=%0d got=%b want=%b", cyc, done, (cyc == exp_done));
      end
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_done cyc=%0d got=%h want=no_result", cyc, shift_reg_output);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          checks++;
          if (shift_reg_output !== e) begin
            errors++;
            $display("FAIL result cyc=%0d got=%h want=%h", cyc, shift_reg_output, e);
          end
        end
      end
    end
  end

  // noise: 0 start low while busy, 1 start held high, 2 random
  task automatic do_op(input logic [1:0] o, input logic [4:0] s, input logic [31:0] d,
                       input int noise, input int gap);
    int a;
    repeat (gap) begin @(negedge clk); start = 1'b0; end
    @(negedge clk);
    start = 1'b1; op = o; shamt = s; data_in = d;
    a = cyc + 1;
    exp_lo = a; exp_hi = a + int'(s); exp_done = a + int'(s);
    exp_q.push_back(model(o, int'(s), d));
    repeat (int'(s) + 1) begin
      @(negedge clk);
      start   = (noise == 1) ? 1'b1 : (noise == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      op      = 2'($urandom);
      shamt   = 5'($urandom);
      data_in = $urandom;
    end
  endtask

  task automatic reset_mid_shift();
    int a;
    @(negedge clk);
    start = 1'b1; op = 2'b00; shamt = 5'd10; data_in = 32'h1234_5678;
    a = cyc + 1;
    exp_lo = a; exp_hi = a + 10; exp_done = a + 10;
    exp_q.push_back(model(2'b00, 10, 32'h1234_5678));
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_hi = a + 2; exp_done = -1;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    checks++;
    if (shift_reg_output !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got=%h/%b/%b want=00000000/0/0", shift_reg_output, busy, done);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = 2'b00; shamt = 5'd0; data_in = 32'h0;
    repeat (3) @(negedge clk);
    checks++;
    if (shift_reg_output !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got=%h/%b/%b want=00000000/0/0", shift_reg_output, busy, done);
    end
    reset = 1'b1;

    do_op(2'b00, 5'd4,  32'h0000_0001, 0, 1);
    do_op(2'b10, 5'd31, 32'h8000_0000, 0, 1);
    do_op(2'b01, 5'd31, 32'h8000_0000, 0, 2);
    do_op(2'b00, 5'd0,  32'hDEAD_BEEF, 1, 1);
    @(negedge clk); start = 1'b0;
    reset_mid_shift();
    do_op(2'b01, 5'd7,  32'hF0F0_1234, 0, 1);
    do_op(2'b11, 5'd1,  32'h0000_0003, 0, 1);
    for (int i = 0; i < 4; i++) do_op(2'b10, 5'd2, 32'h8000_00F0 + i, 1, 0);
    for (int i = 0; i < 60; i++)
      do_op(2'($urandom), 5'($urandom), $urandom, 2, $urandom_range(0, 2));
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d_pending want=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
